io_pattern_player: RTL and testbench

Drives the user-project GPIO outputs (io_out[7:0] / io_oeb[7:0]) with a stored sequence of pattern words, each held for a programmable dwell time. Sits between the firmware-facing register/Wishbone logic (upstream, which loads patterns and issues commands) and the mprj_io pads (downstream), where the pad-level GPIO bench watches the pattern stream, for example 01..0A, FF, 00. Playback starts either immediately or on a rising edge of an external trigger pin.

---
 rtl/io_pattern_player_if.sv | 22 ++
 rtl/io_pattern_player.sv | 180 ++++++++++++++++++
 tb/tb_io_pattern_player.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_pattern_player_if.sv
// Pattern-load channel between the register/Wishbone logic and the pattern player.
// The loader is the master and the player is the slave. The player accepts one
// word on each cycle where wr_valid_i and wr_ready_o are both high.
interface io_pattern_player_if #(
    parameter int IO_W = 8
);
    logic            wr_valid_i;
    logic [IO_W-1:0] wr_data_i;
    logic            wr_ready_o;

    modport master (
        output wr_valid_i,
        output wr_data_i,
        input  wr_ready_o
    );

    modport slave (
        input  wr_valid_i,
        input  wr_data_i,
        output wr_ready_o
    );
endinterface

// File: rtl/io_pattern_player.sv
// GPIO pattern player.
// Stores up to DEPTH pattern words and plays them out on io_out. Each word is
// held for a programmable dwell time. Playback starts either immediately or on
// a synchronised rising edge of trig_i, and it can loop until aborted.
module io_pattern_player #(
    parameter int IO_W    = 8,
    parameter int DEPTH   = 16,
    parameter int DWELL_W = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    io_pattern_player_if.slave       wr,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     trig_en_i,
    input  logic                     loop_i,
    input  logic [DWELL_W-1:0]       dwell_i,
    input  logic                     trig_i,
    input  logic                     oe_en_i,
    output logic [IO_W-1:0]          io_out,
    output logic [IO_W-1:0]          io_oeb,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PLAY
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;      // cycles left on the current entry after this one
    logic [DWELL_W-1:0]   dwell_q, dwell_d;  // latched dwell, never zero
    logic                 loop_q, loop_d;
    logic [IO_W-1:0]      io_out_d;
    logic                 done_d;

    logic                 sync1_q, sync2_q, sync3_q, edge_q;
    logic [IO_W-1:0]      mem [DEPTH];

    logic                 wr_fire;
    logic                 last_entry;
    logic [DWELL_W-1:0]   dwell_eff;
    logic [AW-1:0]        idx_inc;

    assign busy_o        = (state_q != IDLE);
    assign wr.wr_ready_o = (state_q == IDLE) && (count_o < CW'(DEPTH));
    // A clear on the same cycle as a write drops the write.
    assign wr_fire       = wr.wr_valid_i & wr.wr_ready_o & ~clear_i;
    assign dwell_eff     = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
    assign idx_inc       = idx_q + AW'(1);
    assign last_entry    = ({1'b0, idx_q} + CW'(1)) >= count_o;

    // Pattern storage: a write lands at the current fill level.
    // NOTE: the memory has no reset. Its contents are don't-care until written, and count_o is what marks them valid.
    always_ff @(posedge wb_clk_i) begin
        if (wr_fire) begin
            mem[count_o[AW-1:0]] <= wr.wr_data_i;
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic for the playback sequencer.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case statement can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        loop_d   = loop_q;
        io_out_d = io_out;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (count_o == '0) begin
                        done_d = 1'b1;
                    end else begin
                        dwell_d = dwell_eff;
                        loop_d  = loop_i;
                        if (trig_en_i) begin
                            state_d = ARM;
                        end else begin
                            state_d  = PLAY;
                            idx_d    = '0;
                            cnt_d    = dwell_eff - DWELL_W'(1);
                            io_out_d = mem[0];
                        end
                    end
                end
            end
            ARM: begin
                if (abort_i) begin
                    state_d  = IDLE;
                    io_out_d = '0;
                end else if (edge_q) begin
                    state_d  = PLAY;
                    idx_d    = '0;
                    cnt_d    = dwell_q - DWELL_W'(1);
                    io_out_d = mem[0];
                end
            end
            PLAY: begin
                if (abort_i) begin
                    state_d  = IDLE;
                    io_out_d = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!last_entry) begin
                    idx_d    = idx_inc;
                    cnt_d    = dwell_q - DWELL_W'(1);
                    io_out_d = mem[idx_inc];
                end else if (loop_q) begin
                    idx_d    = '0;
                    cnt_d    = dwell_q - DWELL_W'(1);
                    io_out_d = mem[0];
                end else begin
                    state_d  = IDLE;
                    io_out_d = '0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                io_out_d = '0;
            end
        endcase
    end

    // Datapath registers: index, dwell, pad outputs, fill count and trigger synchroniser.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (wb_rst_i) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
            io_out  <= '0;
            io_oeb  <= '1;
            done_o  <= 1'b0;
            count_o <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            io_out  <= io_out_d;
            io_oeb  <= {IO_W{~oe_en_i}};
            done_o  <= done_d;
            if (clear_i) begin
                count_o <= '0;
            end else if (wr_fire) begin
                count_o <= count_o + CW'(1);
            end
            sync1_q <= trig_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            // Only edges that arrive while armed are remembered. Earlier ones are dropped.
            edge_q  <= sync2_q & ~sync3_q & (state_q == ARM);
        end
    end
endmodule

// File: tb/tb_io_pattern_player.sv
// Self-checking bench for io_pattern_player.
// The reference model works from elapsed time: the visible entry is
// (cycles since mem[0] appeared) / dwell. A compare process checks every
// output on every cycle. The directed sections also check hand-computed values.
module tb_io_pattern_player;
    localparam int IO_W    = 8;
    localparam int DEPTH   = 16;
    localparam int DWELL_W = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               wb_rst_i;
    logic               clear_i, start_i, abort_i, trig_en_i, loop_i, trig_i, oe_en_i;
    logic [DWELL_W-1:0] dwell_i;
    logic [IO_W-1:0]    io_out, io_oeb;
    logic               busy_o, done_o;
    logic [CW-1:0]      count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_pattern_player_if #(.IO_W(IO_W)) bus ();

    io_pattern_player #(.IO_W(IO_W), .DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .wr        (bus),
        .clear_i   (clear_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .trig_en_i (trig_en_i),
        .loop_i    (loop_i),
        .dwell_i   (dwell_i),
        .trig_i    (trig_i),
        .oe_en_i   (oe_en_i),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .count_o   (count_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [IO_W-1:0] m_mem [$];
    bit              m_playing, m_armed, m_loop, m_done, m_trig_prev, m_valid;
    int              m_dwell, m_t0, m_arm_edge, m_rise_edge, cyc;
    logic [IO_W-1:0] m_out, m_oeb;

    initial begin
        m_valid = 1'b0;
        cyc     = 0;
    end

    always @(posedge clk) begin
        bit was_busy;
        int n, entry;
        cyc++;
        was_busy = m_playing || m_armed;
        m_done   = 1'b0;
        if (wb_rst_i) begin
            m_mem.delete();
            m_playing   = 1'b0;
            m_armed     = 1'b0;
            m_loop      = 1'b0;
            m_out       = '0;
            m_oeb       = '1;
            m_trig_prev = 1'b0;
            m_rise_edge = -100;
            m_arm_edge  = -100;
        end else begin
            if (trig_i && !m_trig_prev) m_rise_edge = cyc;
            m_trig_prev = trig_i;
            n = m_mem.size();
            if (was_busy) begin
                if (abort_i) begin
                    m_playing = 1'b0;
                    m_armed   = 1'b0;
                    m_out     = '0;
                end else if (m_armed) begin
                    // A rise first sampled at edge E starts playback at edge E+3,
                    // provided the player was already armed before edge E+2.
                    if (m_rise_edge == cyc - 3 && m_arm_edge <= cyc - 2) begin
                        m_armed   = 1'b0;
                        m_playing = 1'b1;
                        m_t0      = cyc;
                        m_out     = m_mem[0];
                    end
                end else begin
                    entry = (cyc - m_t0) / m_dwell;
                    if (m_loop) begin
                        m_out = m_mem[entry % n];
                    end else if (entry >= n) begin
                        m_playing = 1'b0;
                        m_out     = '0;
                        m_done    = 1'b1;
                    end else begin
                        m_out = m_mem[entry];
                    end
                end
            end else if (start_i) begin
                if (n == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_dwell = (dwell_i == 0) ? 1 : int'(dwell_i);
                    m_loop  = loop_i;
                    if (trig_en_i) begin
                        m_armed    = 1'b1;
                        m_arm_edge = cyc;
                    end else begin
                        m_playing = 1'b1;
                        m_t0      = cyc;
                        m_out     = m_mem[0];
                    end
                end
            end
            if (clear_i) m_mem.delete();
            else if (bus.wr_valid_i && !was_busy && n < DEPTH) m_mem.push_back(bus.wr_data_i);
            m_oeb = {IO_W{~oe_en_i}};
        end
        m_valid = 1'b1;
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("io_out",     io_out,         m_out);
            check("io_oeb",     io_oeb,         m_oeb);
            check("busy_o",     busy_o,         m_playing || m_armed);
            check("done_o",     done_o,         m_done);
            check("count_o",    count_o,        m_mem.size());
            check("wr_ready_o", bus.wr_ready_o, !(m_playing || m_armed) && (m_mem.size() < DEPTH));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, written, d, wait_trig, abort_at;
        bit tmode, lmode;
        logic [7:0] exp_b;

        wb_rst_i = 1'b1;
        clear_i = 0; start_i = 0; abort_i = 0; trig_en_i = 0; loop_i = 0;
        trig_i = 0; oe_en_i = 1; dwell_i = '0;
        bus.wr_valid_i = 0; bus.wr_data_i = '0;
        tick();
        tick();
        wb_rst_i = 1'b0;
        check("rst_io_out", io_out, 8'h00);
        check("rst_io_oeb", io_oeb, 8'hFF);
        check("rst_busy",   busy_o, 1'b0);
        check("rst_count",  count_o, 0);

        // Ten entries 01..0A, dwell 10.
        for (int i = 1; i <= 10; i++) begin
            bus.wr_valid_i = 1'b1;
            bus.wr_data_i  = 8'(i);
            tick();
        end
        bus.wr_valid_i = 1'b0;
        check("load10_count", count_o, 10);
        dwell_i = 16'd10;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("play_busy", busy_o, 1'b1);
        for (int e = 0; e < 10; e++) begin
            for (int c = 0; c < 10; c++) begin
                check("seq_value", io_out, 32'(e + 1));
                tick();
            end
        end
        check("seq_end_out",  io_out, 8'h00);
        check("seq_end_done", done_o, 1'b1);
        check("seq_end_busy", busy_o, 1'b0);
        tick();
        check("seq_done_once", done_o, 1'b0);

        // Fill to DEPTH, overflow attempt, clear.
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_valid_i = 1'b1;
            bus.wr_data_i  = 8'($urandom);
            tick();
        end
        check("full_count", count_o, 16);
        check("full_ready", bus.wr_ready_o, 1'b0);
        tick();
        bus.wr_valid_i = 1'b0;
        check("overflow_count", count_o, 16);
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        check("clear_count", count_o, 0);
        check("clear_ready", bus.wr_ready_o, 1'b1);

        // Trigger mode with {FF,00} and dwell 0.
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i = 8'hFF; tick();
        bus.wr_data_i = 8'h00; tick();
        bus.wr_valid_i = 1'b0;
        dwell_i = '0; trig_en_i = 1'b1; loop_i = 1'b0;
        start_i = 1'b1; tick(); start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("arm_busy", busy_o, 1'b1);
            check("arm_hold", io_out, 8'h00);
            tick();
        end
        trig_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("trig_latency", io_out, 8'h00);
        end
        tick();
        check("trig_ff", io_out, 8'hFF);
        tick();
        check("trig_00",      io_out, 8'h00);
        check("trig_00_busy", busy_o, 1'b1);
        tick();
        check("trig_done",      done_o, 1'b1);
        check("trig_done_busy", busy_o, 1'b0);
        trig_i = 1'b0; trig_en_i = 1'b0;
        tick();

        // Loop mode {AA,55} with dwell 3, then abort in the middle of a 55 entry.
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i = 8'hAA; tick();
        bus.wr_data_i = 8'h55; tick();
        bus.wr_valid_i = 1'b0;
        dwell_i = 16'd3; loop_i = 1'b1;
        start_i = 1'b1; tick(); start_i = 1'b0;
        for (int c = 0; c < 22; c++) begin
            exp_b = (((c / 3) % 2) == 0) ? 8'hAA : 8'h55;
            check("loop_value", io_out, exp_b);
            tick();
        end
        check("loop_mid55", io_out, 8'h55);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        check("abort_out",  io_out, 8'h00);
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        loop_i = 1'b0;
        tick();

        // Start with an empty memory, and a clear that collides with a write.
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        start_i = 1'b1; tick(); start_i = 1'b0;
        check("empty_done", done_o, 1'b1);
        check("empty_busy", busy_o, 1'b0);
        tick();
        check("empty_done_once", done_o, 1'b0);
        check("empty_busy2",     busy_o, 1'b0);
        bus.wr_valid_i = 1'b1; bus.wr_data_i = 8'h12; tick();
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        bus.wr_valid_i = 1'b0;
        check("clear_wins", count_o, 0);

        // Reset in the middle of playback.
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i = 8'h11; tick();
        bus.wr_data_i = 8'h22; tick();
        bus.wr_data_i = 8'h33; tick();
        bus.wr_valid_i = 1'b0;
        dwell_i = 16'd5; oe_en_i = 1'b1;
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick();
        check("pre_rst_oeb", io_oeb, 8'h00);
        wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0;
        check("mid_rst_out",   io_out, 8'h00);
        check("mid_rst_oeb",   io_oeb, 8'hFF);
        check("mid_rst_busy",  busy_o, 1'b0);
        check("mid_rst_done",  done_o, 1'b0);
        check("mid_rst_count", count_o, 0);
        tick();

        // Randomized scenarios checked by the model.
        for (int s = 0; s < 40; s++) begin
            clear_i = 1'b1; tick(); clear_i = 1'b0;
            n = $urandom_range(1, DEPTH);
            written = 0;
            while (written < n + ((n == DEPTH) ? 2 : 0)) begin
                bus.wr_valid_i = ($urandom_range(0, 3) != 0);
                bus.wr_data_i  = 8'($urandom);
                oe_en_i        = 1'($urandom);
                if (bus.wr_valid_i) written++;
                tick();
            end
            bus.wr_valid_i = 1'b0;
            d     = $urandom_range(0, 4);
            tmode = 1'($urandom_range(0, 1));
            lmode = ($urandom_range(0, 2) == 0);
            dwell_i = 16'(d); trig_en_i = tmode; loop_i = lmode;
            start_i = 1'b1; tick(); start_i = 1'b0;
            // These inputs only matter at start, so scramble them afterwards.
            dwell_i   = 16'($urandom_range(0, 7));
            trig_en_i = 1'($urandom);
            loop_i    = 1'($urandom);
            wait_trig = $urandom_range(1, 6);
            abort_at  = lmode ? $urandom_range(4, 60)
                              : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1);
            for (int c = 0; c < 2000 && (m_playing || m_armed); c++) begin
                oe_en_i        = 1'($urandom);
                start_i        = ($urandom_range(0, 15) == 0);
                bus.wr_valid_i = ($urandom_range(0, 7) == 0);
                bus.wr_data_i  = 8'($urandom);
                if (tmode && c == wait_trig) trig_i = 1'b1;
                abort_i = (c == abort_at);
                tick();
            end
            start_i = 1'b0; abort_i = 1'b0; bus.wr_valid_i = 1'b0;
            if (m_playing || m_armed) begin
                check("scenario_timeout", 1, 0);
                abort_i = 1'b1; tick(); abort_i = 1'b0;
            end
            trig_i = 1'b0;
            tick(); tick(); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
